// File: rtl/nrdiv_pkg.sv
// Shared types and sizing helpers for the non-restoring divider controller.
package nrdiv_pkg;

    localparam int DEF_SIZE = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ITER    = 2'd1,
        CORRECT = 2'd2,
        DONE    = 2'd3
    } state_e;

    // Iteration counter width; must hold SIZE-1, and never narrower than one bit.
    function automatic int cnt_w(input int size);
        return (size > 2) ? $clog2(size) : 1;
    endfunction

endpackage

// File: rtl/nrdiv_addsub.sv
// Ripple-carry adder/subtractor; subtract is B inverted with carry-in set.
module nrdiv_addsub #(
    parameter int W = 6
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         sub_i,
    output logic [W-1:0] sum_o
);

    // Final carry-out is deliberately dropped: results wrap modulo 2^W.
    always_comb begin
        logic cy;
        logic bb;
        cy    = sub_i;
        sum_o = '0;
        for (int i = 0; i < W; i++) begin
            bb       = b_i[i] ^ sub_i;
            sum_o[i] = a_i[i] ^ bb ^ cy;
            cy       = (a_i[i] & bb) | (cy & (a_i[i] ^ bb));
        end
    end

endmodule

// File: rtl/nonrestoring_div_ctrl.sv
// Sequential unsigned non-restoring divider: SIZE iterations plus one correction step.
// Optional NRDIV_DBZ_CHECK_EN: short-circuit divide-by-zero straight to DONE and raise dbz.
module nonrestoring_div_ctrl
    import nrdiv_pkg::*;
#(
    parameter int SIZE = DEF_SIZE
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [SIZE-1:0] dividend,
    input  logic [SIZE-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [SIZE-1:0] quotient,
    output logic [SIZE-1:0] remainder,
    output logic            dbz
);

    localparam int            CW   = cnt_w(SIZE);
    localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

    state_e          state_q, state_d;
    logic [SIZE:0]   a_q, a_d;
    logic [SIZE:0]   m_q, m_d;
    logic [SIZE-1:0] q_q, q_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SIZE-1:0] quo_q, quo_d;
    logic [SIZE-1:0] rem_q, rem_d;
    logic            dbz_q, dbz_d;

    logic [SIZE:0]   as_a;
    logic [SIZE:0]   as_sum;
    logic            as_sub;

    nrdiv_addsub #(
        .W(SIZE + 1)
    ) u_addsub (
        .a_i  (as_a),
        .b_i  (m_q),
        .sub_i(as_sub),
        .sum_o(as_sum)
    );

    // One shared datapath: ITER feeds the shifted {A,Q}, CORRECT feeds A and adds.
    always_comb begin
        as_a   = a_q;
        as_sub = 1'b0;
        if (state_q == ITER) begin
            as_a   = {a_q[SIZE-1:0], q_q[SIZE-1]};
            as_sub = ~a_q[SIZE];
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        m_d     = m_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    a_d     = '0;
                    q_d     = dividend;
                    m_d     = {1'b0, divisor};
                    cnt_d   = '0;
                    state_d = ITER;
`ifdef NRDIV_DBZ_CHECK_EN
                    if (divisor == '0) begin
                        quo_d   = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end
`endif
                end
            end
            ITER: begin
                a_d   = as_sum;
                q_d   = {q_q[SIZE-2:0], ~as_sum[SIZE]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) state_d = CORRECT;
            end
            CORRECT: begin
                if (a_q[SIZE]) a_d = as_sum;
                quo_d   = q_q;
                rem_d   = a_q[SIZE] ? as_sum[SIZE-1:0] : a_q[SIZE-1:0];
                dbz_d   = 1'b0;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            m_q     <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            m_q     <= m_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy      = (state_q == ITER) || (state_q == CORRECT);
    assign done      = (state_q == DONE);
    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign dbz       = dbz_q;

endmodule

// File: tb/tb_nonrestoring_div_ctrl.sv
// Self-checking bench: directed vector table, corner sequences and a shuffled full sweep.
module tb_nonrestoring_div_ctrl;

    localparam int SIZE     = 5;
    localparam int NORM_LAT = SIZE + 1;
    localparam int MAXV     = (1 << SIZE) - 1;
`ifdef NRDIV_DBZ_CHECK_EN
    localparam int DBZ_LAT  = 0;
    localparam int DBZ_FLAG = 1;
`else
    localparam int DBZ_LAT  = NORM_LAT;
    localparam int DBZ_FLAG = 0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [SIZE-1:0] dividend = '0;
    logic [SIZE-1:0] divisor = '0;
    logic            busy;
    logic            done;
    logic [SIZE-1:0] quotient;
    logic [SIZE-1:0] remainder;
    logic            dbz;

    int checks = 0;
    int errors = 0;

    nonrestoring_div_ctrl #(.SIZE(SIZE)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .quotient (quotient),
        .remainder(remainder),
        .dbz      (dbz)
    );

    always #5 clk = ~clk;

    typedef struct {
        int dd;
        int dv;
        int eq;
        int er;
        int elat;
        int ez;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic issue(input int dd, input int dv);
        @(negedge clk);
        start    = 1'b1;
        dividend = SIZE'(dd);
        divisor  = SIZE'(dv);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Called just after the accepting edge E0. lat = edges after E0 before done is seen.
    // inj >= 0 pulses start with 10/3 for one cycle at that point of the wait.
    task automatic wait_done(input int inj, output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        @(negedge clk);
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            if (lat == inj) begin
                start    = 1'b1;
                dividend = SIZE'(10);
                divisor  = SIZE'(3);
            end else begin
                start = 1'b0;
            end
            lat++;
            @(negedge clk);
        end
        start = 1'b0;
        if (!done) chk("done_timeout", 0, 1);
    endtask

    vec_t tbl[10];
    int   pairs[$];

    initial begin
        int lat, bcnt, seen, dd, dv, tmp, j;
        bit b2b;

        tbl[0] = '{23,  5,  4,  3, NORM_LAT, 0};
        tbl[1] = '{31,  1, 31,  0, NORM_LAT, 0};
        tbl[2] = '{ 3,  7,  0,  3, NORM_LAT, 0};
        tbl[3] = '{ 0,  9,  0,  0, NORM_LAT, 0};
        tbl[4] = '{17,  0, 31, 17, DBZ_LAT,  DBZ_FLAG};
        tbl[5] = '{31, 31,  1,  0, NORM_LAT, 0};
        tbl[6] = '{30, 31,  0, 30, NORM_LAT, 0};
        tbl[7] = '{16,  3,  5,  1, NORM_LAT, 0};
        tbl[8] = '{ 1,  1,  1,  0, NORM_LAT, 0};
        tbl[9] = '{ 0,  0, 31,  0, DBZ_LAT,  DBZ_FLAG};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", int'({busy, done, dbz, quotient, remainder}), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_outputs", int'({busy, done, dbz, quotient, remainder}), 0);

        // Directed vectors
        foreach (tbl[i]) begin
            issue(tbl[i].dd, tbl[i].dv);
            wait_done(-1, lat, bcnt);
            chk($sformatf("vec%0d %0d/%0d quotient", i, tbl[i].dd, tbl[i].dv), int'(quotient), tbl[i].eq);
            chk($sformatf("vec%0d %0d/%0d remainder", i, tbl[i].dd, tbl[i].dv), int'(remainder), tbl[i].er);
            chk($sformatf("vec%0d dbz", i), int'(dbz), tbl[i].ez);
            chk($sformatf("vec%0d done latency", i), lat, tbl[i].elat);
            chk($sformatf("vec%0d busy cycles", i), bcnt, tbl[i].elat);
        end

        // Start while busy is ignored, then back-to-back start from DONE
        issue(23, 5);
        wait_done(2, lat, bcnt);
        chk("ignored_start quotient", int'(quotient), 4);
        chk("ignored_start remainder", int'(remainder), 3);
        chk("ignored_start latency", lat, NORM_LAT);
        start    = 1'b1;
        dividend = SIZE'(10);
        divisor  = SIZE'(3);
        @(posedge clk);
        #1 start = 1'b0;
        chk("b2b accepted busy", int'(busy), 1);
        wait_done(-1, lat, bcnt);
        chk("b2b quotient", int'(quotient), 3);
        chk("b2b remainder", int'(remainder), 1);
        chk("b2b latency", lat, NORM_LAT);

        // Reset mid-operation discards the result
        issue(23, 5);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst outputs", int'({busy, done, dbz, quotient, remainder}), 0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        chk("mid_rst no activity", seen, 0);
        issue(23, 5);
        wait_done(-1, lat, bcnt);
        chk("post_rst quotient", int'(quotient), 4);
        chk("post_rst remainder", int'(remainder), 3);
        chk("post_rst latency", lat, NORM_LAT);

        // Full sweep of nonzero divisors in shuffled order, mixed idle/back-to-back
        for (int a = 0; a <= MAXV; a++)
            for (int b = 1; b <= MAXV; b++)
                pairs.push_back(a * (MAXV + 1) + b);
        for (int i = pairs.size() - 1; i > 0; i--) begin
            j        = $urandom_range(0, i);
            tmp      = pairs[i];
            pairs[i] = pairs[j];
            pairs[j] = tmp;
        end
        b2b = 1'b0;
        foreach (pairs[k]) begin
            dd = pairs[k] / (MAXV + 1);
            dv = pairs[k] % (MAXV + 1);
            if (b2b) begin
                start    = 1'b1;
                dividend = SIZE'(dd);
                divisor  = SIZE'(dv);
                @(posedge clk);
                #1 start = 1'b0;
            end else begin
                issue(dd, dv);
            end
            wait_done(-1, lat, bcnt);
            chk($sformatf("sweep %0d/%0d quotient", dd, dv), int'(quotient), dd / dv);
            chk($sformatf("sweep %0d/%0d remainder", dd, dv), int'(remainder), dd % dv);
            b2b = ($urandom_range(0, 1) == 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
